// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: packed read ports, writeback, issue and bulk-clear
// controls. The master (decode stage) drives requests; the slave is the register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    // Handshake: wt_en, iss_en and clr_req are qualifying strobes sampled on the
    // rising edge with no back-pressure; while clr_busy is high every strobe is
    // dropped, so the master must hold off or accept the loss.
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wt_en;
    logic [ADDR_W-1:0]        wt_addr;
    logic [DATA_W-1:0]        wt_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     dbg_state;

    modport master (
        output rd_addr, wt_en, wt_addr, wt_data, iss_en, iss_addr, clr_req,
        input  rd_data, rd_busy, clr_busy, dbg_state
    );

    modport slave (
        input  rd_addr, wt_en, wt_addr, wt_data, iss_en, iss_addr, clr_req,
        output rd_data, rd_busy, clr_busy, dbg_state
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port GPR bank with busy scoreboard and sequenced bulk clear; r0 is zero.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input logic        clk,
    input logic        rst_n,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wt_ok;
    logic              iss_ok;

    // A clear request in IDLE swallows any write or issue presented alongside it.
    assign wt_ok  = (state_q == IDLE) && !bus.clr_req && bus.wt_en  && (bus.wt_addr  != '0);
    assign iss_ok = (state_q == IDLE) && !bus.clr_req && bus.iss_en && (bus.iss_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue is applied after write so a same-address pair leaves the register busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if ((state_q == IDLE) && bus.clr_req) busy <= '0;
            if (wt_ok) begin
                regs[bus.wt_addr] <= bus.wt_data;
                busy[bus.wt_addr] <= 1'b0;
            end
            if (iss_ok) busy[bus.iss_addr] <= 1'b1;
            if (state_q == CLEAR) regs[cnt_q] <= '0;
        end
    end

    logic [DATA_W-1:0] rd_d [NUM_RD];
    logic [NUM_RD-1:0] rd_b;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] arr_d;
        logic              arr_b;

        assign a     = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign arr_d = (a == '0) ? '0 : regs[a];
        assign arr_b = (state_q == IDLE) && (a != '0) && busy[a];
`ifdef REGFILE_BYPASS_EN
        logic fwd;
        assign fwd     = (state_q == IDLE) && bus.wt_en && (bus.wt_addr == a) && (a != '0);
        assign rd_d[k] = fwd ? bus.wt_data : arr_d;
        assign rd_b[k] = fwd ? (bus.iss_en && (bus.iss_addr == a)) : arr_b;
`else
        assign rd_d[k] = arr_d;
        assign rd_b[k] = arr_b;
`endif
    end

    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) bus.rd_data[k*DATA_W +: DATA_W] = rd_d[k];
    end

    assign bus.rd_busy   = rd_b;
    assign bus.clr_busy  = (state_q == CLEAR);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table for read/write/scoreboard
// behaviour plus directed sequences for forwarding, bulk clear and reset.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk;
  logic rst_n;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;
  logic [DW:0] exp_q[$];

  typedef struct {
    logic          wt_en;
    logic [AW-1:0] wt_addr;
    logic [DW-1:0] wt_data;
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] d0;
    logic          b0;
    logic [DW-1:0] d1;
    logic          b1;
  } vec_t;

  vec_t vecs[12];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic ie, input logic [AW-1:0] ia, input logic cr);
    bus.wt_en    = we;
    bus.wt_addr  = wa;
    bus.wt_data  = wd;
    bus.iss_en   = ie;
    bus.iss_addr = ia;
    bus.clr_req  = cr;
  endtask

  task automatic idle_in();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b1, a, d, 1'b0, '0, 1'b0);
    tick();
    idle_in();
  endtask

  // scoreboard
  task automatic push_exp(input logic [DW-1:0] d, input logic b);
    exp_q.push_back({b, d});
  endtask

  task automatic check_port(input int k, input string nm);
    logic [DW:0] got;
    logic [DW:0] exp;
    got = {bus.rd_busy[k], bus.rd_data[k*DW +: DW]};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s port%0d: no expected entry queued", nm, k);
      return;
    end
    exp = exp_q.pop_front();
    if (got !== exp) begin
      failures++;
      $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b",
               nm, k, got[DW-1:0], got[DW], exp[DW-1:0], exp[DW]);
    end
  endtask

  task automatic check_both(input string nm);
    check_port(0, nm);
    check_port(1, nm);
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  initial begin
    int clr_cycles;
    logic [DW-1:0] fwd_exp;

    vecs[0]  = '{1'b1, 5'd3,  32'h1234_5678, 1'b0, 5'd0, 5'd0,  5'd1,  32'h0,         1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd3,  5'd0,  32'h1234_5678, 1'b0, 32'h0,         1'b0};
    vecs[2]  = '{1'b1, 5'd0,  32'h0000_AAAA, 1'b0, 5'd0, 5'd3,  5'd31, 32'h1234_5678, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7, 5'd0,  5'd31, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 5'd7,  5'd3,  32'h0,         1'b1, 32'h1234_5678, 1'b0};
    vecs[5]  = '{1'b1, 5'd7,  32'h0000_0055, 1'b0, 5'd0, 5'd31, 5'd3,  32'hFFFF_FFFF, 1'b0, 32'h1234_5678, 1'b0};
    vecs[6]  = '{1'b1, 5'd9,  32'h0000_0099, 1'b1, 5'd9, 5'd7,  5'd3,  32'h0000_0055, 1'b0, 32'h1234_5678, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 5'd9,  5'd7,  32'h0000_0099, 1'b1, 32'h0000_0055, 1'b0};
    vecs[8]  = '{1'b1, 5'd9,  32'h0000_1234, 1'b0, 5'd0, 5'd0,  5'd7,  32'h0,         1'b0, 32'h0000_0055, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 5'd9,  5'd9,  32'h0000_1234, 1'b0, 32'h0000_1234, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 5'd0,  5'd9,  32'h0,         1'b0, 32'h0000_1234, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 5'd0,  5'd31, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b0};

    rst_n = 1'b0;
    idle_in();
    set_rd(5'd5, 5'd31);
    #12;
    push_exp(32'h0, 1'b0);
    push_exp(32'h0, 1'b0);
    check_both("reset_state");
    check_val("reset_clr_busy", 32'(bus.clr_busy), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // table: reads observe state before the edge that applies the vector
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].wt_en, vecs[i].wt_addr, vecs[i].wt_data, vecs[i].iss_en, vecs[i].iss_addr, 1'b0);
      set_rd(vecs[i].ra0, vecs[i].ra1);
      push_exp(vecs[i].d0, vecs[i].b0);
      push_exp(vecs[i].d1, vecs[i].b1);
      #1;
      check_both($sformatf("vec%0d", i));
      tick();
    end
    idle_in();

    // same-cycle write to a register being read
    write_reg(5'd4, 32'h0000_1111);
`ifdef REGFILE_BYPASS_EN
    fwd_exp = 32'hCAFE_F00D;
`else
    fwd_exp = 32'h0000_1111;
`endif
    drive(1'b1, 5'd4, 32'hCAFE_F00D, 1'b0, '0, 1'b0);
    set_rd(5'd3, 5'd4);
    push_exp(32'h1234_5678, 1'b0);
    push_exp(fwd_exp, 1'b0);
    #1;
    check_both("wt_same_cycle");
    tick();
    idle_in();
    push_exp(32'h1234_5678, 1'b0);
    push_exp(32'hCAFE_F00D, 1'b0);
    #1;
    check_both("wt_next_cycle");

    // bulk clear
    for (int i = 1; i < 32; i++) write_reg(AW'(i), 32'hA500_0000 | 32'(i));
    drive(1'b0, '0, '0, 1'b1, 5'd10, 1'b0);
    tick();
    idle_in();
    set_rd(5'd10, 5'd0);
    push_exp(32'hA500_000A, 1'b1);
    push_exp(32'h0, 1'b0);
    #1;
    check_both("pre_clear_busy");

    drive(1'b1, 5'd5, 32'h0000_0BAD, 1'b0, '0, 1'b1);
    tick();
    idle_in();
    clr_cycles = 0;
    for (int c = 1; c <= 100; c++) begin
      idle_in();
      if (c == 1) set_rd(5'd1, 5'd31);
      else if (c == 2) set_rd(5'd10, 5'd10);
      else if (c == 5) set_rd(5'd4, 5'd5);
      else set_rd(5'd2, 5'd2);
      if (c == 3) drive(1'b1, 5'd2, 32'h0000_2222, 1'b1, 5'd2, 1'b1);
      #1;
      if (!bus.clr_busy) break;
      clr_cycles++;
      if (c == 1) begin
        push_exp(32'hA500_0001, 1'b0);
        push_exp(32'hA500_001F, 1'b0);
        check_both("clear_first_cycle");
      end
      if (c == 2) begin
        push_exp(32'hA500_000A, 1'b0);
        push_exp(32'hA500_000A, 1'b0);
        check_both("clear_busy_dropped");
      end
      if (c == 5) begin
        push_exp(32'h0, 1'b0);
        push_exp(32'hA500_0005, 1'b0);
        check_both("clear_progress");
      end
      tick();
    end
    idle_in();
    check_val("clear_cycles", 32'(clr_cycles), 32'd31);

    for (int i = 0; i < 32; i += 2) begin
      set_rd(AW'(i), AW'(i + 1));
      push_exp(32'h0, 1'b0);
      push_exp(32'h0, 1'b0);
      #1;
      check_both($sformatf("cleared_r%0d", i));
    end

    write_reg(5'd2, 32'h0000_0002);
    set_rd(5'd2, 5'd10);
    push_exp(32'h0000_0002, 1'b0);
    push_exp(32'h0, 1'b0);
    #1;
    check_both("post_clear_write");

    // asynchronous reset with no clock edge
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5, 1'b0);
    tick();
    idle_in();
    set_rd(5'd5, 5'd2);
    push_exp(32'hDEAD_BEEF, 1'b1);
    push_exp(32'h0000_0002, 1'b0);
    #1;
    check_both("pre_reset");
    #2;
    rst_n = 1'b0;
    push_exp(32'h0, 1'b0);
    push_exp(32'h0, 1'b0);
    #1;
    check_both("async_reset");
    tick();
    rst_n = 1'b1;
    tick();

    // reset during clear
    write_reg(5'd31, 32'h0000_0077);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    tick();
    idle_in();
    tick();
    #1;
    check_val("mid_clear_active", 32'(bus.clr_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_val("mid_clear_reset", 32'(bus.clr_busy), 32'h0);
    set_rd(5'd31, 5'd1);
    push_exp(32'h0, 1'b0);
    push_exp(32'h0, 1'b0);
    #1;
    check_both("mid_clear_reset_data");
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    check_val("post_reset_idle", 32'(bus.clr_busy), 32'h0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with per-register busy scoreboard and sequenced bulk clear. It is the next-generation GPR bank for the RISC32i_CPU decode stage. Decode reads operands, marks a destination busy at issue, and writeback releases it. Register 0 is hardwired to zero and is never busy.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: address width; depth is `2**ADDR_W`.
- `NUM_RD`, default 2: number of read ports, 1..4.
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `rd_addr`, input, `NUM_RD*ADDR_W`: packed read addresses; port k is `[k*ADDR_W +: ADDR_W]`.
- `rd_data`, output, `NUM_RD*DATA_W`: packed read data, combinational.
- `rd_busy`, output, `NUM_RD`: scoreboard bit of the addressed register, combinational.
- `wt_en`, input, 1: writeback enable.
- `wt_addr`, input, `ADDR_W`: writeback address.
- `wt_data`, input, `DATA_W`: writeback data.
- `iss_en`, input, 1: mark `iss_addr` busy (pending producer).
- `iss_addr`, input, `ADDR_W`: destination of the issuing instruction.
- `clr_req`, input, 1: single-cycle request to zero the whole file.
- `clr_busy`, output, 1: clear sequence in progress.

## Operation
- **Storage**
  - Array `reg[1 .. 2**ADDR_W-1]`.
  - Read of address 0 returns 0, with `rd_busy` = 0.
  - Writes and issues to address 0 are ignored.
- **Write**
  - Rising edge with `wt_en` high and `wt_addr` != 0 and state IDLE: `reg[wt_addr] <= wt_data` and `busy[wt_addr] <= 0`.
- **Issue**
  - Rising edge with `iss_en` high and `iss_addr` != 0 and state IDLE: `busy[iss_addr] <= 1`.
  - If issue and write target the same address in the same cycle, the data is written and busy ends set: the issue wins, because it is the newer producer.
- **FSM states**
  - IDLE:
    - `clr_req` high moves the FSM to CLEAR.
    - On that same edge, all busy bits clear and counter `cnt <= 1`.
    - A write or issue in that cycle is dropped.
  - CLEAR:
    - Each cycle, `reg[cnt] <= 0` and `cnt <= cnt+1`.
    - When `cnt == 2**ADDR_W-1`, that register is cleared and the FSM returns to IDLE.
    - `clr_req`, `wt_en` and `iss_en` are ignored.
- **Reads during CLEAR**
  - Return the current array contents; cleared registers read 0, not-yet-cleared registers read old data.
  - `rd_busy` reads 0.
- `clr_busy` = (state == CLEAR).

## Timing
- **Reset** (asynchronous, active-low): all registers 0, all busy bits 0, state IDLE, `cnt` 0, `clr_busy` 0.
- Read latency is zero (combinational). A write is visible on the non-bypass path the cycle after the write edge.
- Clear occupancy: `clr_busy` is high for exactly `2**ADDR_W-1` cycles, starting the cycle after the `clr_req` edge.
- Reset asserted mid-clear aborts the sequence immediately with the full reset state.
- `wt_addr`, `iss_addr` and `rd_addr` are compared on the full `ADDR_W` bits; there is no wrap or aliasing.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- **Defined:** in IDLE, if `wt_en` is high and `wt_addr` == `rd_addr[k]` != 0:
  - `rd_data[k]` = `wt_data` in the same cycle (write-through forwarding).
  - `rd_busy[k]` = 0, unless `iss_en` targets the same address that cycle.
- **Undefined:**
  - `rd_data[k]` always reflects the array.
  - `rd_busy[k]` = `busy[rd_addr[k]]`.
  - A same-cycle write is seen one cycle later.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-cycle after writing 0xDEADBEEF to r5 -> `rd_data` for r5 = 0 and `rd_busy` = 0 immediately, asynchronously.
- **Write/read on two ports:** write r3 = 0x12345678 and r31 = 0xFFFFFFFF; read r3 on port 0 and r31 on port 1 -> both values next cycle. A write of 0xAAAA to r0 -> r0 still reads 0.
- **Scoreboard:**
  - Issue r7 -> `rd_busy` = 1 from the next cycle.
  - Write r7 = 0x55 -> busy = 0 and data = 0x55 the cycle after.
  - Same-cycle issue and write to r9 -> data updated, busy = 1.
- **Bypass** (`REGFILE_BYPASS_EN` defined): write r4 = 0xCAFEF00D while port 1 reads r4 -> `rd_data` = 0xCAFEF00D in the same cycle, with `rd_busy` = 0.
- **No bypass** (macro undefined): same stimulus as the bypass test -> old r4 value in that cycle, 0xCAFEF00D in the next.
- **Clear:**
  - Fill r1..r31 with nonzero values and issue r10; pulse `clr_req`.
  - Expect `clr_busy` high for exactly 31 cycles, all busy bits 0 right after the `clr_req` edge, and every register 0 once `clr_busy` falls.
  - A write to r2 during the clear is ignored and r2 reads 0.
  - A second `clr_req` during the clear has no effect.
